regfile_write_arbiter: RTL and testbench

//   Owns the single write port of the 8x16 register_file. Arbitrates two write

---
 rtl/regfile_write_arbiter_if.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Request/clear/write-port bundle between the two write requesters, the clear
// controller and the register_file write port.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  clear_start;
  logic                  busy;
  logic                  clear_done;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;

  logic                  write;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;

  // master: requesters + clear controller + register_file; slave: the arbiter
  modport master (
    output clear_start,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  busy, clear_done,
    input  write, wrAddr, wrData
  );

  modport slave (
    input  clear_start,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output busy, clear_done,
    output write, wrAddr, wrData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the register file: round-robin arbitration of two
// valid/ready requesters plus a clear sweep writing CLEAR_VALUE to every register.
module regfile_write_arbiter #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 3,
  parameter int                    NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // NUM_REGS must equal 2**ADDR_WIDTH, so the sweep counter is an address.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state_q;
  logic                  ptr_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  busy_q;
  logic                  clear_done_q;

  logic                  grant0;
  logic                  grant1;
  logic                  accept_en;
  logic                  ready0;
  logic                  ready1;

  // ptr_q = 0 prefers requester 0 on contention; ready never looks at addr/data.
  always_comb begin
    grant0    = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
    grant1    = bus.req1_valid & (~bus.req0_valid |  ptr_q);
    accept_en = reset & (state_q == RUN) & ~bus.clear_start;
    ready0    = accept_en & grant0;
    ready1    = accept_en & grant1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      ptr_q        <= 1'b0;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.clear_start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            write_q <= 1'b0;
          end else if (ready0 & bus.req0_valid) begin
            write_q   <= 1'b1;
            wr_addr_q <= bus.req0_addr;
            wr_data_q <= bus.req0_data;
            ptr_q     <= 1'b1;
          end else if (ready1 & bus.req1_valid) begin
            write_q   <= 1'b1;
            wr_addr_q <= bus.req1_addr;
            wr_data_q <= bus.req1_data;
            ptr_q     <= 1'b0;
          end else begin
            write_q <= 1'b0;
          end
        end
        CLEAR: begin
          // clear_start is deliberately ignored here: no restart, no extension
          write_q   <= 1'b1;
          wr_addr_q <= cnt_q;
          wr_data_q <= CLEAR_VALUE;
          if (cnt_q == LAST_ADDR) begin
            state_q      <= RUN;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.write      = write_q;
  assign bus.wrAddr     = wr_addr_q;
  assign bus.wrData     = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.clear_done = clear_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared against
// a transaction-level reference model and a behavioural register file.
module tb_regfile_write_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .CLEAR_VALUE('0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // behavioural register_file fed by the arbiter's write port (not reset)
  logic [DW-1:0] rf [NR] = '{default: '0};
  always @(posedge clk) if (bus.write) rf[bus.wrAddr] <= bus.wrData;

  // reference model state
  logic [DW-1:0] mem_exp [NR];
  bit            m_clr;
  int            m_idx;
  int            m_pref;
  logic          exp_write;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          exp_busy;
  logic          exp_done;

  int n_tests;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("write", 32'(bus.write), 32'(exp_write));
    check_val("wrAddr", 32'(bus.wrAddr), 32'(exp_addr));
    check_val("wrData", 32'(bus.wrData), 32'(exp_data));
    check_val("busy", 32'(bus.busy), 32'(exp_busy));
    check_val("clear_done", 32'(bus.clear_done), 32'(exp_done));
  endtask

  task automatic check_regs();
    for (int i = 0; i < NR; i++)
      check_val($sformatf("reg%0d", i), 32'(rf[i]), 32'(mem_exp[i]));
  endtask

  task automatic drive(input bit cs,
                       input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.clear_start = cs;
    bus.req0_valid  = v0;
    bus.req0_addr   = a0;
    bus.req0_data   = d0;
    bus.req1_valid  = v1;
    bus.req1_addr   = a1;
    bus.req1_data   = d1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // One clock cycle. Called at posedge+1 with inputs applied; returns at posedge+1.
  task automatic cycle(output bit acc0, output bit acc1);
    bit            e0, e1;
    logic          n_write;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_data;
    logic          n_done;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_clr && !bus.clear_start) begin
      if (bus.req0_valid && bus.req1_valid) begin
        e0 = (m_pref == 0);
        e1 = (m_pref == 1);
      end else begin
        e0 = bus.req0_valid;
        e1 = bus.req1_valid;
      end
    end
    check_val("req0_ready", 32'(bus.req0_ready), 32'(e0));
    check_val("req1_ready", 32'(bus.req1_ready), 32'(e1));

    n_write = 1'b0;
    n_addr  = exp_addr;
    n_data  = exp_data;
    n_done  = 1'b0;
    if (m_clr) begin
      n_write = 1'b1;
      n_addr  = AW'(m_idx);
      n_data  = '0;
      m_idx++;
      if (m_idx == NR) begin
        m_clr  = 1'b0;
        m_idx  = 0;
        n_done = 1'b1;
      end
    end else if (bus.clear_start) begin
      m_clr = 1'b1;
      m_idx = 0;
    end else if (e0) begin
      n_write = 1'b1;
      n_addr  = bus.req0_addr;
      n_data  = bus.req0_data;
      m_pref  = 1;
    end else if (e1) begin
      n_write = 1'b1;
      n_addr  = bus.req1_addr;
      n_data  = bus.req1_data;
      m_pref  = 0;
    end
    acc0 = e0;
    acc1 = e1;

    @(posedge clk);
    #1;
    if (exp_write) mem_exp[exp_addr] = exp_data;
    exp_write = n_write;
    exp_addr  = n_addr;
    exp_data  = n_data;
    exp_busy  = m_clr;
    exp_done  = n_done;
    check_outputs();
  endtask

  // Asserted mid-cycle; outputs must drop without a clock edge.
  task automatic async_reset();
    reset = 1'b0;
    #1;
    check_val("rst_write", 32'(bus.write), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.clear_done), 32'd0);
    check_val("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check_val("rst_ready1", 32'(bus.req1_ready), 32'd0);
    m_clr     = 1'b0;
    m_idx     = 0;
    m_pref    = 0;
    exp_write = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    @(posedge clk);
    drive_idle();
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    bit            acc0, acc1;
    bit            h0, h1;
    bit            v0, v1, cs;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            busy_cnt, done_cnt, bound;
    bit            accepted;
    logic          done_at_acc;

    n_tests   = 0;
    n_fail    = 0;
    m_clr     = 1'b0;
    m_idx     = 0;
    m_pref    = 0;
    exp_write = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    for (int i = 0; i < NR; i++) mem_exp[i] = '0;

    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // single request from req0
    drive(1'b0, 1'b1, 3'd3, 16'd23, 1'b0, '0, '0);
    cycle(acc0, acc1);
    drive_idle();
    cycle(acc0, acc1);
    check_val("reg3_after_single", 32'(rf[3]), 32'd23);

    // async reset while a write is on the port and req0 is still valid
    drive(1'b0, 1'b1, 3'd1, 16'd77, 1'b0, '0, '0);
    cycle(acc0, acc1);
    drive(1'b0, 1'b1, 3'd1, 16'd77, 1'b0, '0, '0);
    async_reset();
    check_val("reg1_not_written", 32'(rf[1]), 32'd0);

    // contention: both held valid, grants must alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 3'd2, 16'd31, 1'b1, 3'd5, 16'd45);
      cycle(acc0, acc1);
      check_val($sformatf("rr_grant%0d", i), 32'(acc1), 32'(i % 2));
    end
    drive_idle();
    cycle(acc0, acc1);
    check_regs();

    // clear sweep over preloaded registers
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle(acc0, acc1);
    drive_idle();
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.clear_done) done_cnt++;
      cycle(acc0, acc1);
    end
    check_val("clear_busy_cycles", 32'(busy_cnt), 32'd8);
    check_val("clear_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < NR; i++)
      check_val($sformatf("cleared_reg%0d", i), 32'(rf[i]), 32'd0);

    // req1 held through a sweep, second clear_start mid-sweep ignored
    drive(1'b0, 1'b0, '0, '0, 1'b1, 3'd6, 16'd99);
    cycle(acc0, acc1);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 3'd7, 16'd55);
    cycle(acc0, acc1);
    accepted    = 1'b0;
    done_at_acc = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      drive(i == 3, 1'b0, '0, '0, 1'b1, 3'd7, 16'd55);
      done_at_acc = bus.clear_done;
      cycle(acc0, acc1);
      accepted = acc1;
    end
    check_val("req1_accepted", 32'(accepted), 32'd1);
    check_val("req1_accept_at_done", 32'(done_at_acc), 32'd1);
    drive_idle();
    cycle(acc0, acc1);
    check_val("reg7_after_sweep", 32'(rf[7]), 32'd55);

    // reset in the middle of a sweep while address 4 is on the port
    for (int i = 4; i < NR; i++) begin
      drive(1'b0, 1'b1, AW'(i), DW'(16'h40 + i), 1'b0, '0, '0);
      cycle(acc0, acc1);
    end
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle(acc0, acc1);
    drive_idle();
    bound = 0;
    while (!(exp_write && exp_busy && exp_addr == 3'd4) && bound < 20) begin
      cycle(acc0, acc1);
      bound++;
    end
    check_val("sweep_reached_addr4", 32'(bound < 20), 32'd1);
    async_reset();
    check_val("reg4_kept", 32'(rf[4]), 32'h44);
    check_val("reg3_cleared", 32'(rf[3]), 32'd0);
    check_regs();

    // randomized traffic; requesters hold their request until accepted
    h0 = 1'b0;
    h1 = 1'b0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!h0) begin
        v0 = ($urandom_range(0, 9) < 6);
        a0 = AW'($urandom);
        d0 = DW'($urandom);
      end
      if (!h1) begin
        v1 = ($urandom_range(0, 9) < 6);
        a1 = AW'($urandom);
        d1 = DW'($urandom);
      end
      cs = ($urandom_range(0, 39) == 0);
      drive(cs, v0, a0, d0, v1, a1, d1);
      cycle(acc0, acc1);
      h0 = v0 && !acc0;
      h1 = v1 && !acc1;
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        h0 = 1'b0;
        h1 = 1'b0;
      end
      if (n % 100 == 99) check_regs();
    end
    drive_idle();
    cycle(acc0, acc1);
    check_regs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
